// File: rtl/deser_frame_sequencer.sv
// Frame sequencer for one DeserializerWithCounter: start pulse, word capture on RCO, stall abort.
// Latency: RCO to word_valid_o is 1 cycle; deser_start_o/deser_reset_o/frame_done_o are 1-cycle registered pulses.
// Backpressure: a 4-deep (FIFO_DEPTH) word buffer absorbs word_ready_i stalls; words arriving while full are dropped and flagged.
//
// Ports:
//   clock_i, reset_n_i            system clock (rising edge), asynchronous active-low reset
//   enable_i                      frame capture request (level, sampled in IDLE only)
//   clear_err_i                   1-cycle pulse, clears overflow_o and timeout_err_o
//   deser_start_o, deser_reset_o  start / active-high reset pulses to the deserializer
//   deser_busy_i, deser_rco_i     deserializer busy and word-complete strobe
//   deser_data_i                  deserializer word, valid while deser_rco_i=1
//   word_data_o/_valid_o/_ready_i word output stream (FIFO head)
//   frame_done_o                  1-cycle pulse per completed frame
//   overflow_o, timeout_err_o     sticky error flags
//   frame_count_o                 completed frames, wraps at 16 bits
//
// Build option DESER_SEQ_AUTO_REARM_EN: when defined, DONE goes straight back to START while
// enable_i is high (back-to-back frames). When undefined, one frame per enable_i rising edge.
module deser_frame_sequencer #(
    parameter int WORD_SIZE       = 8,
    parameter int WORDS_PER_FRAME = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic                 clear_err_i,
    output logic                 deser_start_o,
    output logic                 deser_reset_o,
    input  logic                 deser_busy_i,
    input  logic                 deser_rco_i,
    input  logic [WORD_SIZE-1:0] deser_data_i,
    output logic [WORD_SIZE-1:0] word_data_o,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic                 frame_done_o,
    output logic                 overflow_o,
    output logic                 timeout_err_o,
    output logic [15:0]          frame_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORDS_PER_FRAME + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BUSY, S_RECEIVE, S_DONE, S_ABORT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   word_cnt_q;
    logic [TW-1:0]   tmo_q;
    logic            deser_start_q, deser_reset_q, frame_done_q;
    logic            overflow_q, timeout_err_q;
    logic [15:0]     frame_count_q;

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;

    logic fifo_empty, fifo_full, pop, push_ok, ovf_set;
    logic rco_rx, tmo_hit, start_ok;

    // RCO only means something while a frame is being received.
    assign rco_rx  = (state_q == S_RECEIVE) && deser_rco_i;
    // A word arriving on the last allowed cycle beats the timeout.
    assign tmo_hit = ((state_q == S_WAIT_BUSY) || (state_q == S_RECEIVE))
                     && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !rco_rx;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
                        && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && word_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok    = rco_rx && (!fifo_full || pop);
    assign ovf_set    = rco_rx && fifo_full && !pop;

`ifdef DESER_SEQ_AUTO_REARM_EN
    assign start_ok = enable_i;
`else
    // Re-armed by enable_i being low for a cycle; consumed when a frame starts.
    logic armed_q;
    assign start_ok = enable_i && armed_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            armed_q <= 1'b1;
        end else if (!enable_i) begin
            armed_q <= 1'b1;
        end else if (state_q == S_IDLE) begin
            armed_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            tmo_q         <= '0;
            deser_start_q <= 1'b0;
            deser_reset_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            deser_start_q <= 1'b0;
            deser_reset_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q       <= S_START;
                        deser_start_q <= 1'b1;
                    end
                end
                S_START: begin
                    word_cnt_q <= '0;
                    tmo_q      <= '0;
                    state_q    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tmo_hit) begin
                        state_q       <= S_ABORT;
                        deser_reset_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                        if (deser_busy_i) begin
                            state_q <= S_RECEIVE;
                        end
                    end
                end
                S_RECEIVE: begin
                    if (tmo_hit) begin
                        state_q       <= S_ABORT;
                        deser_reset_q <= 1'b1;
                    end else if (rco_rx) begin
                        // Counted even when the word was dropped, so framing stays aligned.
                        tmo_q      <= '0;
                        word_cnt_q <= word_cnt_q + CW'(1);
                        if (word_cnt_q == CW'(WORDS_PER_FRAME - 1)) begin
                            state_q       <= S_DONE;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_DONE: begin
`ifdef DESER_SEQ_AUTO_REARM_EN
                    if (enable_i) begin
                        state_q       <= S_START;
                        deser_start_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_ABORT: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            // A new error in the clearing cycle keeps the flag set.
            timeout_err_q <= tmo_hit | (timeout_err_q & ~clear_err_i);
            overflow_q    <= ovf_set | (overflow_q & ~clear_err_i);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= deser_data_i;
    end

    assign word_valid_o  = !fifo_empty;
    // Storage is not reset; mask it so the output reads zero while empty.
    assign word_data_o   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign deser_start_o = deser_start_q;
    assign deser_reset_o = deser_reset_q;
    assign frame_done_o  = frame_done_q;
    assign overflow_o    = overflow_q;
    assign timeout_err_o = timeout_err_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_deser_frame_sequencer.sv
module tb_deser_frame_sequencer;
    localparam int DEPTH = 4;
`ifdef DESER_SEQ_AUTO_REARM_EN
    localparam int EXP_HELD_FRAMES = 3;
`else
    localparam int EXP_HELD_FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, enable = 1'b0, clear_err = 1'b0;
    logic       deser_busy = 1'b0, deser_rco = 1'b0, word_ready = 1'b0;
    logic [7:0] deser_data = 8'h00;
    logic       deser_start, deser_reset, word_valid, frame_done, overflow, timeout_err;
    logic [7:0] word_data;
    logic [15:0] frame_count;

    deser_frame_sequencer dut (
        .clock_i       (clk),
        .reset_n_i     (reset_n),
        .enable_i      (enable),
        .clear_err_i   (clear_err),
        .deser_start_o (deser_start),
        .deser_reset_o (deser_reset),
        .deser_busy_i  (deser_busy),
        .deser_rco_i   (deser_rco),
        .deser_data_i  (deser_data),
        .word_data_o   (word_data),
        .word_valid_o  (word_valid),
        .word_ready_i  (word_ready),
        .frame_done_o  (frame_done),
        .overflow_o    (overflow),
        .timeout_err_o (timeout_err),
        .frame_count_o (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    int exp_fc = 0;
    int n_start = 0, n_reset = 0, n_done = 0;
    int s0, n;
    bit ok, seen;
    logic [7:0] mon_exp;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        bit         rdy;
        bit         ovf;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n) begin
            if (deser_start) n_start++;
            if (deser_reset) n_reset++;
            if (frame_done)  n_done++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", word_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word_data", word_data, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (deser_start) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic send_word(input logic [7:0] d, input bit rdy_push);
        deser_rco  = 1'b1;
        deser_data = d;
        if (rdy_push) word_ready = 1'b1;
        if (exp_q.size() < DEPTH || word_ready) exp_q.push_back(d);
        step();
        deser_rco  = 1'b0;
        deser_data = 8'h00;
        if (rdy_push) word_ready = 1'b0;
    endtask

    // en_mode: 0 drop enable after start, 1 keep it, 2 drop it while in DONE.
    task automatic do_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input int en_mode, input bit rdy_push, output bit fok);
        bit f;
        wait_start(f);
        fok = f;
        if (!f) return;
        if (en_mode == 0) enable = 1'b0;
        deser_busy = 1'b1;
        step();
        step();
        send_word(d0, rdy_push);
        step();
        send_word(d1, rdy_push);
        deser_busy = 1'b0;
        exp_fc++;
        check("frame_done", frame_done, 1);
        check("frame_count", frame_count, exp_fc[15:0]);
        if (en_mode == 2) enable = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{d0: 8'hA5, d1: 8'h3C, rdy: 1'b1, ovf: 1'b0};
        tbl[1] = '{d0: 8'h11, d1: 8'h22, rdy: 1'b0, ovf: 1'b0};
        tbl[2] = '{d0: 8'h33, d1: 8'h44, rdy: 1'b0, ovf: 1'b0};
        tbl[3] = '{d0: 8'h55, d1: 8'h66, rdy: 1'b0, ovf: 1'b1};

        repeat (3) step();
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_deser_start", deser_start, 0);
        check("rst_deser_reset", deser_reset, 0);
        check("rst_frame_done", frame_done, 0);
        reset_n = 1'b1;
        step();

        // Normal frame, then three frames into a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            s0 = n_start;
            word_ready = tbl[i].rdy;
            enable = 1'b1;
            do_frame(tbl[i].d0, tbl[i].d1, 0, 1'b0, ok);
            check("frame_started", ok, 1);
            check("overflow", overflow, tbl[i].ovf);
            check("start_pulses", n_start - s0, 1);
        end
        check("full_valid", word_valid, 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop in the same cycle.
        enable = 1'b1;
        do_frame(8'h77, 8'h88, 0, 1'b1, ok);
        check("pushpop_started", ok, 1);
        check("pushpop_no_ovf", overflow, 0);
        check("pushpop_head", word_data, 8'h33);
        check("pushpop_valid", word_valid, 1);
        word_ready = 1'b1;
        repeat (6) step();
        check("drained_valid", word_valid, 0);
        check("drained_all", exp_q.size(), 0);

        // Busy never rises: abort; clear_err in the abort cycle loses to the new error.
        s0 = n_done;
        enable = 1'b1;
        wait_start(seen);
        check("tmo_started", seen, 1);
        enable = 1'b0;
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            n++;
            if (deser_reset) break;
            clear_err = (n == 1024);
        end
        clear_err = 1'b0;
        check("tmo_cycles", n, 1025);
        check("tmo_err_set", timeout_err, 1);
        check("tmo_no_done", n_done - s0, 0);
        step();
        check("tmo_reset_1cyc", deser_reset, 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("tmo_err_cleared", timeout_err, 0);

        // Back in IDLE; an RCO on the last allowed cycle beats the timeout.
        s0 = n_reset;
        enable = 1'b1;
        wait_start(seen);
        check("rco_win_started", seen, 1);
        enable = 1'b0;
        deser_busy = 1'b1;
        for (int i = 0; i < 1024; i++) step();
        send_word(8'hE1, 1'b0);
        check("rco_win_no_abort", n_reset - s0, 0);
        step();
        send_word(8'hE2, 1'b0);
        deser_busy = 1'b0;
        exp_fc++;
        check("rco_win_done", frame_done, 1);
        check("rco_win_count", frame_count, exp_fc[15:0]);
        check("rco_win_no_err", timeout_err, 0);
        repeat (3) step();

        // Reset in the middle of a frame.
        enable = 1'b1;
        wait_start(seen);
        enable = 1'b0;
        deser_busy = 1'b1;
        step();
        step();
        word_ready = 1'b0;
        send_word(8'h5A, 1'b0);
        step();
        check("pre_rst_valid", word_valid, 1);
        reset_n = 1'b0;
        #2;
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_count", frame_count, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_tmo", timeout_err, 0);
        exp_q.delete();
        exp_fc = 0;
        deser_busy = 1'b0;
        word_ready = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        enable = 1'b1;
        do_frame(8'hC3, 8'h96, 0, 1'b0, ok);
        check("post_rst_frame", ok, 1);
        repeat (3) step();

        // enable held high across several frames.
        s0 = n_done;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            do_frame(8'(8'h10 + f), 8'(8'h20 + f), (f == 2) ? 2 : 1, 1'b0, ok);
            if (!ok) break;
        end
        check("held_frames", n_done - s0, EXP_HELD_FRAMES);
        enable = 1'b0;
        step();
        enable = 1'b1;
        do_frame(8'h5C, 8'hC5, 0, 1'b0, ok);
        check("retoggle_frame", ok, 1);
        repeat (4) step();
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
